ctrl_relu_wb_seq: RTL and testbench
===================================

Name: ctrl_relu_wb_seq

Overview:
- Parametrised write-back sequencer for the ReLU output mux.
- Steps a lane-select index across a programmable number of lanes per row, and repeats over a programmable number of rows.
- Each lane is presented to the downstream writer with a valid/ready handshake.
- Signals completion to the datapath FSM with a single-cycle relu_done pulse; sits between the MAC accumulator bank output mux and the memory write-back port.

Parameters:
- N_LANES, 4, number of accumulator lanes feeding the ReLU mux (>=2)
- SEL_W, $clog2(N_LANES), width of sel_mux_relu (derived, not overridden)
- CNT_W, $clog2(N_LANES+1), width of lane-count config
- ROW_W, 8, width of row-count config

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- cnt_load  in  1  capture max_val and rows_val (honoured in IDLE only)
- max_val  in  CNT_W  lanes per row, legal 1..N_LANES
- rows_val  in  ROW_W  rows per job, legal 1..2^ROW_W-1
- start  in  1  begin a job (honoured in IDLE only)
- cnt_clear  in  1  abort/clear to IDLE
- out_ready  in  1  downstream accepts current lane
- sel_mux_relu  out  SEL_W  lane select to ReLU mux
- wb_valid  out  1  current lane valid for write-back
- relu_done  out  1  one-cycle pulse, job finished
- busy  out  1  high in RUN
- cfg_err  out  1  one-cycle pulse, illegal config was saturated

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE, lane_idx=0, row_cnt=0.
  - max_q=N_LANES, rows_q=1.
  - sel_mux_relu=0, wb_valid=0, relu_done=0, busy=0, cfg_err=0.
- Priority, highest first: rst_n, cnt_clear, cnt_load, start, handshake.
- States: IDLE, RUN, DONE.
- IDLE:
  - cnt_load=1 captures max_q and rows_q.
  - max_val==0 or max_val>N_LANES: max_q=N_LANES, cfg_err pulses the next cycle.
  - rows_val==0: rows_q=1, cfg_err pulses.
  - start=1 with cnt_load=0: state=RUN, lane_idx=0, row_cnt=0.
  - start together with cnt_load: the load wins and start is dropped.
- RUN:
  - wb_valid=1, busy=1, sel_mux_relu=lane_idx.
  - Transfer occurs when wb_valid & out_ready.
  - On transfer with lane_idx<max_q-1: lane_idx+1.
  - On transfer with lane_idx==max_q-1: lane_idx=0 (wrap-around); then if row_cnt==rows_q-1, state=DONE, else row_cnt+1.
  - No transfer: all state held; sel_mux_relu stable while wb_valid && !out_ready.
- DONE:
  - relu_done=1 for exactly one cycle, wb_valid=0, busy=0.
  - Next cycle: state=IDLE.
- Ignored inputs: start, and cnt_load in RUN or DONE, with no side effect and no cfg_err.
- cnt_clear in any state: next cycle state=IDLE, lane_idx=0, row_cnt=0, all outputs 0, relu_done suppressed; max_q and rows_q retained.
- Timing:
  - All outputs come from registered state/lane_idx; no combinational path from out_ready to any output.
  - Latency start→first wb_valid: 1 cycle.
  - Last transfer→relu_done: 1 cycle.
  - Minimum job length: max_q*rows_q transfer cycles + 2.
- sel_mux_relu in IDLE/DONE: 0.
- Counters never exceed max_q-1 or rows_q-1; no overflow at the ROW_W maximum.

Test Plan:
1. Reset, load max_val=4, rows_val=1, start, out_ready=1 → sel 0,1,2,3 on consecutive cycles with wb_valid=1; relu_done pulses 1 cycle after sel=3; busy falls; no cfg_err.
2. max_val=3, rows_val=2, out_ready=1 → sel sequence 0,1,2,0,1,2; single relu_done pulse after the 6th transfer.
3. Backpressure: max_val=4, out_ready low for 3 cycles while sel=1 → sel holds 1, wb_valid stays 1; sequence resumes 2,3 on release; total 4 transfers.
4. Illegal config: max_val=0 then max_val=7 (N_LANES=4), rows_val=0 → cfg_err pulses each load; job then runs 4 lanes × 1 row.
5. cnt_clear asserted mid-RUN at sel=2 → next cycle IDLE, wb_valid=0, sel=0, no relu_done; restart with start runs from sel=0 using the retained config.
6. Synchronous reset mid-RUN, plus start/cnt_load in RUN → reset takes effect only at a clock edge, giving reset values and max_q=4; start/cnt_load during RUN leave the sequence and config unchanged.

Source files
------------

// File: rtl/ctrl_relu_wb_seq.sv
// Write-back sequencer for the ReLU output mux.
// Steps a lane-select index over max_q lanes per row for rows_q rows, presenting
// each lane with a valid/ready handshake, then pulses relu_done for one cycle.
module ctrl_relu_wb_seq #(
  parameter int unsigned N_LANES = 4,
  parameter int unsigned ROW_W   = 8,
  localparam int unsigned SEL_W  = $clog2(N_LANES),
  localparam int unsigned CNT_W  = $clog2(N_LANES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cnt_load,
  input  logic [CNT_W-1:0] max_val,
  input  logic [ROW_W-1:0] rows_val,
  input  logic             start,
  input  logic             cnt_clear,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel_mux_relu,
  output logic             wb_valid,
  output logic             relu_done,
  output logic             busy,
  output logic             cfg_err
);

  localparam logic [CNT_W-1:0] MaxReset = CNT_W'(N_LANES);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
  localparam logic [ROW_W-1:0] RowOne   = ROW_W'(1);
  localparam logic [SEL_W-1:0] SelOne   = SEL_W'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] lane_q, lane_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [ROW_W-1:0] rows_q, rows_d;
  logic             cfg_err_q, cfg_err_d;

  logic xfer, last_lane, last_row, max_bad, rows_bad;

  assign xfer      = (state_q == StRun) && out_ready;
  // max_q >= 1 and rows_q >= 1 always hold, so the subtractions cannot wrap.
  assign last_lane = (CNT_W'(lane_q) == (max_q - CntOne));
  assign last_row  = (row_q == (rows_q - RowOne));
  assign max_bad   = (max_val == '0) || (max_val > MaxReset);
  assign rows_bad  = (rows_val == '0);

  // Next-state: clear overrides everything, then load, then start, then handshake.
  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    row_d     = row_q;
    max_d     = max_q;
    rows_d    = rows_q;
    cfg_err_d = 1'b0;
    if (cnt_clear) begin
      state_d = StIdle;
      lane_d  = '0;
      row_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cnt_load) begin
            // Illegal values are saturated to safe defaults and flagged.
            max_d     = max_bad ? MaxReset : max_val;
            rows_d    = rows_bad ? RowOne : rows_val;
            cfg_err_d = max_bad | rows_bad;
          end else if (start) begin
            state_d = StRun;
            lane_d  = '0;
            row_d   = '0;
          end
        end
        StRun: begin
          if (xfer) begin
            if (last_lane) begin
              lane_d = '0;
              if (last_row) begin
                state_d = StDone;
                row_d   = '0;
              end else begin
                row_d = row_q + RowOne;
              end
            end else begin
              lane_d = lane_q + SelOne;
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // State and config registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      lane_q    <= '0;
      row_q     <= '0;
      max_q     <= MaxReset;
      rows_q    <= RowOne;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      row_q     <= row_d;
      max_q     <= max_d;
      rows_q    <= rows_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Outputs decode registered state only; out_ready never reaches an output.
  always_comb begin
    wb_valid     = (state_q == StRun);
    busy         = (state_q == StRun);
    relu_done    = (state_q == StDone);
    sel_mux_relu = (state_q == StRun) ? lane_q : '0;
    cfg_err      = cfg_err_q;
  end

endmodule

// File: tb/tb_ctrl_relu_wb_seq.sv
// Scoreboard bench for ctrl_relu_wb_seq: the driver pushes expected events
// (transfer lane, done, cfg error) and a negedge monitor pops and compares.
module tb_ctrl_relu_wb_seq;

  localparam int N_LANES = 4;
  localparam int ROW_W   = 8;
  localparam int SEL_W   = $clog2(N_LANES);
  localparam int CNT_W   = $clog2(N_LANES + 1);

  localparam int KXfer = 1;
  localparam int KDone = 2;
  localparam int KErr  = 3;

  typedef struct {
    int kind;
    int val;
  } item_t;

  logic             clk = 0;
  logic             rst_n = 0;
  logic             cnt_load = 0;
  logic [CNT_W-1:0] max_val = '0;
  logic [ROW_W-1:0] rows_val = '0;
  logic             start = 0;
  logic             cnt_clear = 0;
  logic             out_ready = 0;
  logic [SEL_W-1:0] sel_mux_relu;
  logic             wb_valid;
  logic             relu_done;
  logic             busy;
  logic             cfg_err;

  ctrl_relu_wb_seq #(.N_LANES(N_LANES), .ROW_W(ROW_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cnt_load    (cnt_load),
    .max_val     (max_val),
    .rows_val    (rows_val),
    .start       (start),
    .cnt_clear   (cnt_clear),
    .out_ready   (out_ready),
    .sel_mux_relu(sel_mux_relu),
    .wb_valid    (wb_valid),
    .relu_done   (relu_done),
    .busy        (busy),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  item_t exp_q[$];
  bit    mon_en = 0;
  int    cyc = 0;
  int    done_cnt = 0;
  int    last_xfer_cyc = -10;
  bit    prev_stall = 0;
  logic [SEL_W-1:0] prev_sel = '0;

  // Reference config as the spec defines it after reset.
  int m_max  = N_LANES;
  int m_rows = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int val);
    item_t it;
    it.kind = kind;
    it.val  = val;
    exp_q.push_back(it);
  endtask

  task automatic pop_cmp(input string name, input int kind, input int val);
    item_t it;
    if (exp_q.size() == 0) begin
      check({name, "_unexpected"}, kind * 16 + val, 0);
    end else begin
      it = exp_q.pop_front();
      check(name, kind * 16 + val, it.kind * 16 + it.val);
    end
  endtask

  // Monitor: samples mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (wb_valid && out_ready) begin
        pop_cmp("xfer", KXfer, int'(sel_mux_relu));
        last_xfer_cyc = cyc;
      end
      if (relu_done) begin
        pop_cmp("done", KDone, 0);
        check("done_latency", cyc - last_xfer_cyc, 1);
        check("done_no_valid", wb_valid, 0);
        done_cnt++;
      end
      if (cfg_err) pop_cmp("cfg_err", KErr, 0);
      if (prev_stall) begin
        check("stall_valid", wb_valid, 1);
        check("stall_sel", sel_mux_relu, prev_sel);
      end
      check("busy_eq_valid", busy, wb_valid);
      prev_stall = wb_valid && !out_ready && !cnt_clear && rst_n;
      prev_sel   = sel_mux_relu;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int mv, input int rv);
    max_val  = mv[CNT_W-1:0];
    rows_val = rv[ROW_W-1:0];
    cnt_load = 1;
    if (mv == 0 || mv > N_LANES || rv == 0) push(KErr, 0);
    m_max  = (mv == 0 || mv > N_LANES) ? N_LANES : mv;
    m_rows = (rv == 0) ? 1 : rv;
    step();
    cnt_load = 0;
  endtask

  task automatic push_job();
    for (int r = 0; r < m_rows; r++)
      for (int l = 0; l < m_max; l++) push(KXfer, l);
    push(KDone, 0);
  endtask

  // mode 0: always ready, 1: random ready, 2: three stall cycles at sel 1.
  task automatic run_job(input int mode, input bit inject);
    int n = 0;
    int d0 = done_cnt;
    int stall = 3;
    bit injected = 0;
    push_job();
    start = 1;
    step();
    start = 0;
    check("start_latency", wb_valid, 1);
    while (done_cnt == d0 && n < 2000) begin
      case (mode)
        0: out_ready = 1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (sel_mux_relu == 1 && stall > 0) begin
            out_ready = 0;
            stall--;
          end else begin
            out_ready = 1;
          end
        end
      endcase
      if (inject && !injected && wb_valid && sel_mux_relu == 1) begin
        // Illegal config in RUN must be ignored with no cfg_err.
        start    = 1;
        cnt_load = 1;
        max_val  = '0;
        rows_val = '0;
        injected = 1;
      end
      step();
      start    = 0;
      cnt_load = 0;
      n++;
    end
    out_ready = 0;
    check("job_timeout", n < 2000, 1);
    check("idle_busy", busy, 0);
    check("idle_sel", sel_mux_relu, 0);
  endtask

  // Abort a job at sel 2 with cnt_clear or with a synchronous reset.
  task automatic run_abort(input bit use_reset);
    int n = 0;
    push_job();
    start = 1;
    step();
    start = 0;
    out_ready = 1;
    while (!(wb_valid && sel_mux_relu == 2) && n < 100) begin
      step();
      n++;
    end
    check("abort_reach", n < 100, 1);
    out_ready = 0;
    if (use_reset) rst_n = 0;
    else cnt_clear = 1;
    @(negedge clk);
    if (use_reset) check("sync_rst_not_yet", busy, 1);
    step();
    rst_n     = 1;
    cnt_clear = 0;
    exp_q.delete();
    if (use_reset) begin
      m_max  = N_LANES;
      m_rows = 1;
    end
    check("abort_valid", wb_valid, 0);
    check("abort_sel", sel_mux_relu, 0);
    check("abort_busy", busy, 0);
    check("abort_done", relu_done, 0);
    repeat (3) step();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    int mv, rv;
    rst_n = 0;
    repeat (2) step();
    check("rst_sel", sel_mux_relu, 0);
    check("rst_valid", wb_valid, 0);
    check("rst_done", relu_done, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_err", cfg_err, 0);
    rst_n  = 1;
    mon_en = 1;
    step();

    // Basic 4x1 and 3x2 jobs.
    do_load(4, 1);
    run_job(0, 0);
    do_load(3, 2);
    run_job(0, 0);

    // Backpressure at sel 1.
    do_load(4, 1);
    run_job(2, 0);

    // Illegal configs saturate to 4 lanes x 1 row.
    do_load(0, 1);
    do_load(7, 0);
    run_job(0, 0);

    // Clear mid-run, then restart with retained config.
    do_load(4, 1);
    run_abort(0);
    run_job(0, 0);

    // Ignored start/load in RUN, config unchanged afterwards.
    do_load(3, 2);
    run_job(1, 1);
    run_job(0, 0);

    // Reset mid-run restores 4x1 config.
    run_abort(1);
    run_job(0, 0);

    // Randomized configs and backpressure.
    for (int i = 0; i < 8; i++) begin
      mv = $urandom_range(0, 7);
      rv = $urandom_range(0, 4);
      do_load(mv, rv);
      run_job(1, 0);
    end

    repeat (4) step();
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
